// File: rtl/ps_setpoint_framer_pkg.sv
// Shared types and helpers for the power-supply setpoint framer.
package ps_setpoint_framer_pkg;

    localparam logic [7:0] FRAME_MAGIC = 8'hA5;

    typedef enum logic {
        CAPTURE,
        RESYNC
    } cap_state_e;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        CHKSUM
    } tx_state_e;

    function automatic int frame_words(input int result_count);
        return result_count + 2;
    endfunction

    function automatic logic [31:0] pack_header(input logic [7:0] count, input logic [15:0] seq);
        return {FRAME_MAGIC, count, seq};
    endfunction

endpackage

// File: rtl/ps_setpoint_frame_buffer.sv
// Two-bank setpoint store: one write port, one registered read port.
module ps_setpoint_frame_buffer #(
    parameter int RESULT_COUNT       = 24,
    parameter int FLOAT_WIDTH        = 32,
    parameter int RESULT_COUNT_WIDTH = (RESULT_COUNT == 1) ? 1 : $clog2(RESULT_COUNT)
) (
    input  logic                          clk,
    input  logic                          wr_en_i,
    input  logic                          wr_bank_i,
    input  logic [RESULT_COUNT_WIDTH-1:0] wr_index_i,
    input  logic [FLOAT_WIDTH-1:0]        wr_data_i,
    input  logic                          rd_bank_i,
    input  logic [RESULT_COUNT_WIDTH-1:0] rd_index_i,
    output logic [FLOAT_WIDTH-1:0]        rd_data_o
);

    logic [FLOAT_WIDTH-1:0] mem_q [2][RESULT_COUNT];
    logic [FLOAT_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_index_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_bank_i][rd_index_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ps_setpoint_framer.sv
// Captures fixed-length setpoint bursts into a double buffer and re-emits each
// one as a header + setpoints + XOR checksum frame on the link stream.
module ps_setpoint_framer
    import ps_setpoint_framer_pkg::*;
#(
    parameter int RESULT_COUNT       = 24,
    parameter int FLOAT_WIDTH        = 32,
    parameter int RESULT_COUNT_WIDTH = (RESULT_COUNT == 1) ? 1 : $clog2(RESULT_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   linkEnable,
    input  logic                   SETPOINT_TVALID,
    input  logic                   SETPOINT_TLAST,
    input  logic [FLOAT_WIDTH-1:0] SETPOINT_TDATA,
    output logic                   LINK_TVALID,
    input  logic                   LINK_TREADY,
    output logic                   LINK_TLAST,
    output logic [FLOAT_WIDTH-1:0] LINK_TDATA,
    output logic [15:0]            sequence_o,
    output logic [15:0]            overrunCount,
    output logic [15:0]            lengthErrorCount
);

    // Link handshake: a word transfers on a clock edge where LINK_TVALID && LINK_TREADY;
    // once raised, LINK_TVALID/TDATA/TLAST hold until that transfer happens.
    localparam logic [RESULT_COUNT_WIDTH-1:0] LAST_INDEX = RESULT_COUNT_WIDTH'(RESULT_COUNT - 1);
    localparam logic [RESULT_COUNT_WIDTH-1:0] INDEX_ONE  = RESULT_COUNT_WIDTH'(1);

    cap_state_e                    cap_state_q, cap_state_d;
    logic [RESULT_COUNT_WIDTH-1:0] wr_index_q, wr_index_d;
    logic                          cap_bank_q, cap_bank_d;
    logic [15:0]                   overrun_q, overrun_d;
    logic [15:0]                   len_err_q, len_err_d;
    logic                          burst_done, handoff, tx_free, link_hs, wr_en;

    tx_state_e                     tx_state_q, tx_state_d;
    logic [RESULT_COUNT_WIDTH-1:0] tx_count_q, tx_count_d;
    logic [RESULT_COUNT_WIDTH-1:0] rd_index_q, rd_index_d;
    logic [FLOAT_WIDTH-1:0]        tdata_q, tdata_d;
    logic [FLOAT_WIDTH-1:0]        chk_q, chk_d;
    logic [15:0]                   seq_q, seq_d;
    logic [FLOAT_WIDTH-1:0]        rd_data, header_word;

    assign link_hs     = LINK_TVALID && LINK_TREADY;
    assign tx_free     = (tx_state_q == IDLE) || ((tx_state_q == CHKSUM) && link_hs);
    assign header_word = FLOAT_WIDTH'(pack_header(8'(RESULT_COUNT), seq_q));
    assign wr_en       = SETPOINT_TVALID && (cap_state_q == CAPTURE);

    always_comb begin
        cap_state_d = cap_state_q;
        wr_index_d  = wr_index_q;
        cap_bank_d  = cap_bank_q;
        overrun_d   = overrun_q;
        len_err_d   = len_err_q;
        burst_done  = 1'b0;
        if (SETPOINT_TVALID) begin
            if (cap_state_q == RESYNC) begin
                if (SETPOINT_TLAST) begin
                    cap_state_d = CAPTURE;
                end
            end else if (SETPOINT_TLAST) begin
                wr_index_d = '0;
                if (wr_index_q == LAST_INDEX) begin
                    burst_done = 1'b1;
                end else begin
                    len_err_d = len_err_q + 16'd1;
                end
            end else if (wr_index_q == LAST_INDEX) begin
                wr_index_d  = '0;
                len_err_d   = len_err_q + 16'd1;
                cap_state_d = RESYNC;
            end else begin
                wr_index_d = wr_index_q + INDEX_ONE;
            end
        end
        handoff = burst_done && linkEnable && tx_free;
        if (handoff) begin
            cap_bank_d = !cap_bank_q;
        end else if (burst_done && linkEnable) begin
            overrun_d = overrun_q + 16'd1;
        end
    end

    // rd_index_d is the RAM address; rd_index_q is the word now sitting in rd_data,
    // so the next word is always ready the cycle after a handshake.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_count_d = tx_count_q;
        rd_index_d = rd_index_q;
        tdata_d    = tdata_q;
        chk_d      = chk_q;
        seq_d      = seq_q;
        case (tx_state_q)
            IDLE: ;
            HEADER: begin
                if (link_hs) begin
                    tx_state_d = DATA;
                    tx_count_d = '0;
                    tdata_d    = rd_data;
                    chk_d      = chk_q ^ rd_data;
                    seq_d      = seq_q + 16'd1;
                    if (rd_index_q != LAST_INDEX) rd_index_d = rd_index_q + INDEX_ONE;
                end
            end
            DATA: begin
                if (link_hs) begin
                    if (tx_count_q == LAST_INDEX) begin
                        tx_state_d = CHKSUM;
                        tdata_d    = chk_q;
                    end else begin
                        tx_count_d = tx_count_q + INDEX_ONE;
                        tdata_d    = rd_data;
                        chk_d      = chk_q ^ rd_data;
                        if (rd_index_q != LAST_INDEX) rd_index_d = rd_index_q + INDEX_ONE;
                    end
                end
            end
            CHKSUM: begin
                if (link_hs) tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
        if (handoff) begin
            tx_state_d = HEADER;
            tx_count_d = '0;
            rd_index_d = '0;
            tdata_d    = header_word;
            chk_d      = header_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state_q <= CAPTURE;
            wr_index_q  <= '0;
            cap_bank_q  <= 1'b0;
            overrun_q   <= '0;
            len_err_q   <= '0;
            tx_state_q  <= IDLE;
            tx_count_q  <= '0;
            rd_index_q  <= '0;
            tdata_q     <= '0;
            chk_q       <= '0;
            seq_q       <= '0;
        end else begin
            cap_state_q <= cap_state_d;
            wr_index_q  <= wr_index_d;
            cap_bank_q  <= cap_bank_d;
            overrun_q   <= overrun_d;
            len_err_q   <= len_err_d;
            tx_state_q  <= tx_state_d;
            tx_count_q  <= tx_count_d;
            rd_index_q  <= rd_index_d;
            tdata_q     <= tdata_d;
            chk_q       <= chk_d;
            seq_q       <= seq_d;
        end
    end

    // Transmit side always reads the bank the capture side will not be writing next cycle.
    ps_setpoint_frame_buffer #(
        .RESULT_COUNT      (RESULT_COUNT),
        .FLOAT_WIDTH       (FLOAT_WIDTH),
        .RESULT_COUNT_WIDTH(RESULT_COUNT_WIDTH)
    ) u_buffer (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_bank_i (cap_bank_q),
        .wr_index_i(wr_index_q),
        .wr_data_i (SETPOINT_TDATA),
        .rd_bank_i (!cap_bank_d),
        .rd_index_i(rd_index_d),
        .rd_data_o (rd_data)
    );

    assign LINK_TVALID      = (tx_state_q != IDLE);
    assign LINK_TLAST       = (tx_state_q == CHKSUM);
    assign LINK_TDATA       = tdata_q;
    assign sequence_o       = seq_q;
    assign overrunCount     = overrun_q;
    assign lengthErrorCount = len_err_q;

endmodule

// File: tb/tb_ps_setpoint_framer.sv
// Self-checking bench for ps_setpoint_framer against a burst/frame level reference model.
module tb_ps_setpoint_framer;

    localparam int RC = 4;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          link_en;
    logic          sp_valid, sp_last;
    logic [FW-1:0] sp_data;
    logic          link_valid, link_ready, link_last;
    logic [FW-1:0] link_data;
    logic [15:0]   seq_o, overrun_o, lenerr_o;

    always #5 clk = ~clk;

    ps_setpoint_framer #(
        .RESULT_COUNT(RC),
        .FLOAT_WIDTH (FW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .linkEnable      (link_en),
        .SETPOINT_TVALID (sp_valid),
        .SETPOINT_TLAST  (sp_last),
        .SETPOINT_TDATA  (sp_data),
        .LINK_TVALID     (link_valid),
        .LINK_TREADY     (link_ready),
        .LINK_TLAST      (link_last),
        .LINK_TDATA      (link_data),
        .sequence_o      (seq_o),
        .overrunCount    (overrun_o),
        .lengthErrorCount(lenerr_o)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [FW-1:0] exp_q[$];     // words the link still owes for the current frame
    logic [FW-1:0] beats_q[$];   // beats of the burst being captured
    logic [FW-1:0] obs_q[$];     // words seen transferring on the link
    logic [FW-1:0] snap_q[$];
    bit            m_resync;
    logic [15:0]   m_seq, m_overrun, m_lenerr;
    int            ready_mode;   // 0: always ready, 1: toggle, 2: random, 3: never
    bit            ready_phase;
    logic [31:0]   t1_exp [6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs, advance the model over the coming edge, then clock.
    task automatic step();
        logic [FW-1:0] hdr, chk;
        bit            hs, free, complete, is_hdr;
        case (ready_mode)
            0:       link_ready = 1'b1;
            1:       begin link_ready = ready_phase; ready_phase = !ready_phase; end
            2:       link_ready = 1'($urandom_range(0, 1));
            default: link_ready = 1'b0;
        endcase
        #1;
        check("valid", link_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("tdata", link_data, exp_q[0]);
            check("tlast", link_last, exp_q.size() == 1);
        end
        check("sequence", seq_o, m_seq);
        check("overrun", overrun_o, m_overrun);
        check("lenerr", lenerr_o, m_lenerr);
        if (link_valid && link_ready) obs_q.push_back(link_data);

        hs       = (exp_q.size() > 0) && link_ready;
        free     = (exp_q.size() == 0) || ((exp_q.size() == 1) && link_ready);
        complete = 1'b0;
        if (sp_valid) begin
            if (m_resync) begin
                if (sp_last) m_resync = 1'b0;
            end else begin
                beats_q.push_back(sp_data);
                if (sp_last && beats_q.size() == RC) begin
                    complete = 1'b1;
                end else if (sp_last) begin
                    m_lenerr++;
                    beats_q.delete();
                end else if (beats_q.size() == RC) begin
                    m_lenerr++;
                    beats_q.delete();
                    m_resync = 1'b1;
                end
            end
        end
        if (hs) begin
            is_hdr = (exp_q.size() == RC + 2);
            void'(exp_q.pop_front());
            if (is_hdr) m_seq++;
        end
        if (complete) begin
            if (link_en) begin
                if (free) begin
                    hdr = {8'hA5, 8'(RC), m_seq};
                    chk = hdr;
                    exp_q.push_back(hdr);
                    foreach (beats_q[i]) begin
                        exp_q.push_back(beats_q[i]);
                        chk ^= beats_q[i];
                    end
                    exp_q.push_back(chk);
                end else begin
                    m_overrun++;
                end
            end
            beats_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat(input logic [FW-1:0] data, input bit last);
        sp_valid = 1'b1;
        sp_data  = data;
        sp_last  = last;
        step();
        sp_valid = 1'b0;
        sp_last  = 1'b0;
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) beat($urandom, i == n - 1);
    endtask

    task automatic drain();
        int budget = 200;
        while (exp_q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic reset_pulse();
        rst_n    = 1'b0;
        sp_valid = 1'b0;
        sp_last  = 1'b0;
        #1;
        check("rst_valid", link_valid, 1'b0);
        check("rst_tlast", link_last, 1'b0);
        check("rst_tdata", link_data, 32'h0);
        check("rst_seq", seq_o, 16'h0);
        check("rst_overrun", overrun_o, 16'h0);
        check("rst_lenerr", lenerr_o, 16'h0);
        exp_q.delete();
        beats_q.delete();
        m_resync  = 1'b0;
        m_seq     = '0;
        m_overrun = '0;
        m_lenerr  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        t1_exp = '{32'hA5040000, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000, 32'h65040000};
        sp_valid   = 1'b0;
        sp_last    = 1'b0;
        sp_data    = '0;
        link_en    = 1'b1;
        link_ready = 1'b1;
        ready_mode = 0;
        ready_phase = 1'b1;
        @(negedge clk);
        reset_pulse();

        // Directed reference frame with checksum 65040000.
        obs_q.delete();
        beat(32'h3F800000, 1'b0);
        beat(32'h40000000, 1'b0);
        beat(32'hBF800000, 1'b0);
        beat(32'h00000000, 1'b1);
        drain();
        check("t1_words", obs_q.size(), 6);
        if (obs_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check("t1_word", obs_q[i], t1_exp[i]);
        end
        check("t1_seq", seq_o, 16'd1);

        // Alternating TREADY: same frame content, six transfers.
        ready_mode  = 1;
        ready_phase = 1'b1;
        obs_q.delete();
        burst(RC);
        snap_q = exp_q;
        drain();
        check("t2_words", obs_q.size(), 6);
        if (obs_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check("t2_word", obs_q[i], snap_q[i]);
        end

        // Reset in the middle of a frame.
        ready_mode = 0;
        burst(RC);
        idle(2);
        reset_pulse();

        // Overrun while the link is stalled, then recovery.
        ready_mode = 3;
        obs_q.delete();
        burst(RC);
        idle(2);
        burst(RC);
        check("t3_overrun", overrun_o, 16'd1);
        ready_mode = 0;
        drain();
        idle(3);
        burst(RC);
        drain();
        check("t3_frames", obs_q.size(), 12);
        if (obs_q.size() == 12) begin
            check("t3_hdr0", obs_q[0], 32'hA5040000);
            check("t3_hdr1", obs_q[6], 32'hA5040001);
        end

        // Short burst, over-long burst with resync, then a good burst.
        burst(2);
        for (int i = 0; i < 5; i++) beat($urandom, 1'b0);
        beat($urandom, 1'b1);
        check("t4_lenerr", lenerr_o, 16'd2);
        obs_q.delete();
        burst(RC);
        drain();
        check("t4_words", obs_q.size(), 6);

        // Hand-off landing exactly on the checksum transfer.
        obs_q.delete();
        burst(RC);
        idle(2);
        burst(RC);
        drain();
        check("t5_words", obs_q.size(), 12);
        check("t5_overrun", overrun_o, 16'd1);

        // Randomized bursts, gaps, TREADY and linkEnable.
        ready_mode = 2;
        for (int it = 0; it < 250; it++) begin
            int kind, n;
            kind    = $urandom_range(0, 9);
            link_en = ($urandom_range(0, 7) != 0);
            if (kind < 7)       n = RC;
            else if (kind == 7) n = $urandom_range(1, RC - 1);
            else                n = RC + $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                beat($urandom, i == n - 1);
            end
            idle($urandom_range(0, 4));
        end
        ready_mode = 0;
        link_en    = 1'b1;
        drain();
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps_setpoint_framer.md
Name: ps_setpoint_framer

Overview:
- Sits directly downstream of the power-supply setpoint calculator.
- Captures each burst of RESULT_COUNT floating-point setpoints from its AXI stream, which has no back pressure and ends each burst with TLAST, into a double buffer.
- Emits each complete burst as a framed, checksummed AXI stream for the power-supply link serializer.
- Counts dropped and malformed bursts for diagnostics.

Parameters:
- RESULT_COUNT, 24, setpoints per burst and per frame.
- FLOAT_WIDTH, 32, setpoint and link word width.
- RESULT_COUNT_WIDTH, RESULT_COUNT==1 ? 1 : $clog2(RESULT_COUNT), index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- linkEnable  in  1  when low, completed bursts are discarded.
- SETPOINT_TVALID  in  1  input beat valid; no TREADY exists.
- SETPOINT_TLAST  in  1  last setpoint of burst.
- SETPOINT_TDATA  in  FLOAT_WIDTH  float setpoint in amperes.
- LINK_TVALID  out  1  output beat valid.
- LINK_TREADY  in  1  downstream ready.
- LINK_TLAST  out  1  final (checksum) word of frame.
- LINK_TDATA  out  FLOAT_WIDTH  frame word.
- sequence  out  16  sequence number of the next frame header.
- overrunCount  out  16  bursts dropped because the transmitter was busy.
- lengthErrorCount  out  16  malformed bursts discarded.

Behaviour:
- Reset: LINK_TVALID=0, LINK_TLAST=0, LINK_TDATA=0, sequence=0, all counters 0, write index 0, capture bank 0, capture FSM=CAPTURE, transmit FSM=IDLE.
- Frame format, RESULT_COUNT+2 words:
  - Header {8'hA5, RESULT_COUNT[7:0], sequence}.
  - RESULT_COUNT setpoints in arrival order.
  - Checksum: XOR of the header and all setpoint words.
- Capture FSM, states CAPTURE and RESYNC:
  - CAPTURE: each valid beat is written to bank[cap][wrIndex] and wrIndex increments.
  - A beat with TLAST at wrIndex==RESULT_COUNT-1 completes the burst.
  - A beat with TLAST at any other index: lengthErrorCount++, wrIndex<=0, stay in CAPTURE.
  - A beat at wrIndex==RESULT_COUNT-1 without TLAST: lengthErrorCount++, wrIndex<=0, go to RESYNC.
  - RESYNC: beats are discarded; a TLAST beat returns to CAPTURE with wrIndex=0. No further errors are counted while in RESYNC.
- Completion, evaluated in the cycle of the final beat:
  - If linkEnable=0: discard silently, with no counter change.
  - Else if the transmitter is free: hand off the bank, cap<=!cap, and the transmitter begins on the next cycle. "Free" means transmit FSM in IDLE, or in CHKSUM with the final handshake (TVALID&&TREADY) occurring this cycle.
  - Else: overrunCount++, the burst is dropped, and cap is unchanged so the bank is reused.
  - wrIndex<=0 in all three cases.
- Transmit FSM, states IDLE → HEADER → DATA → CHKSUM → IDLE:
  - TVALID is high in HEADER, DATA and CHKSUM. Each state advances only on a TVALID&&TREADY handshake.
  - DATA advances after RESULT_COUNT handshakes.
  - TLAST is asserted only in CHKSUM.
  - TDATA and TLAST are held stable while TVALID&&!TREADY.
  - Checksum is accumulated as words are presented.
  - sequence increments, wrapping, on the header handshake.
  - Back-to-back frames are allowed: a hand-off in CHKSUM's final cycle goes straight to HEADER with no idle cycle.
- Bank access:
  - The transmitter reads only the bank not selected by cap.
  - Read data is registered one cycle; the FSM prefetches so that TVALID has no bubbles while TREADY is held high.
- linkEnable falling mid-frame: the frame in flight completes normally.
- All counters wrap at 16 bits.

Decomposition:
- Package ps_setpoint_framer_pkg holds:
  - FRAME_MAGIC = 8'hA5.
  - Function frame_words(RESULT_COUNT) = RESULT_COUNT+2.
  - Capture-state enum {CAPTURE, RESYNC}.
  - Transmit-state enum {IDLE, HEADER, DATA, CHKSUM}.
  - Header-packing function.
- One sub-module, ps_setpoint_frame_buffer: a two-bank simple dual-port RAM of 2*RESULT_COUNT x FLOAT_WIDTH. Write address is {bank, index}; it has a registered read port.

Test Plan:
- RESULT_COUNT=4, TREADY=1, burst 3F800000, 40000000, BF800000, 00000000 with TLAST on the 4th → link emits A5040000, the four words, then 65040000 with TLAST; sequence becomes 1.
- TREADY toggled 1/0 every cycle during a frame → identical word sequence; TDATA is constant across each stall; 6 handshakes occur.
- Second burst completes while the first frame is stalled with TREADY=0 → overrunCount=1; only one frame is emitted. A third burst after that frame finishes → emitted with header sequence 0001.
- Burst with TLAST on beat 2, then 5 beats with no TLAST, then a valid 4-beat burst → lengthErrorCount=2; the 6th beat (TLAST) resyncs; the final burst frames correctly.
- Hand-off in the exact cycle of the previous checksum handshake → next header appears on the following cycle; overrunCount stays 0.
- rst_n pulsed low mid-frame → LINK_TVALID=0 immediately, all counters 0; the next complete burst emits a header with sequence 0000.
